alu_ctrl_mdu: RTL and testbench
===============================

# alu_ctrl_mdu

Parametrised execute-stage control block for the MIPS datapath. It decodes `ALUop`/`funct`/`opcode` into the 4-bit ALU operation code for single-cycle ops. It also owns an iterative multiply/divide unit with HI/LO registers, so mul/div run multi-cycle and stall the pipeline instead of occupying the single-cycle ALU. It sits between the main control unit and the ALU, and feeds the hazard unit through `stall`.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4.
- `CNT_W`, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  a real instruction is present in EX this cycle
- `flush`  in  1  squash the EX instruction and any in-flight mul/div
- `ALUop`  in  2  from the main control (control_signal[5:4])
- `funct`  in  6  instruction[5:0]
- `opcode`  in  6  instruction[31:26]
- `a`, `b`  in  WIDTH  rs and rt operand values
- `control_out`  out  4  ALU operation code
- `ex_illegal`  out  1  unrecognised R-type funct
- `stall`  out  1  hold the pipeline at EX this cycle
- `busy`  out  1  iteration in progress
- `done`  out  1  one-cycle pulse; HI/LO were just updated
- `hi`, `lo`  out  WIDTH  architectural HI/LO

## Operation
- Decode is combinational:
  - `ALUop`=00 → 2 (add).
  - `ALUop`=x1 → 6 (sub).
  - `ALUop`=1x decodes `funct`: 20h→2, 22h→6, 24h→0, 25h→1, 2Ah→7, 00h→8, 03h→12, 26h→10, 27h→11, 1Ah→4, 10h (mfhi)→13, 12h (mflo)→14. For 02h: `opcode`≠0 → 5 (mul), otherwise 9 (srl).
  - Any other funct → 3 and `ex_illegal`=1. `ex_illegal` is 0 when `ALUop`≠1x.
- MDU op = code 4 or 5. Start = `valid_i` & MDU op & state ∈ {IDLE, DONE} & !`flush`.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE → MUL or DIV on start.
  - MUL/DIV → DONE after WIDTH iterations.
  - DONE → IDLE unless a new start occurs.
  - Any state → IDLE on `flush`.
- On start:
  - Latch |a| and |b|, the operand signs, and the op.
  - Clear the counter.
  - Division with `b`=0 skips iteration and goes straight to DONE with HI=`a`, LO=all-ones.
- MUL: unsigned shift-add of magnitudes, one bit per cycle; 2·WIDTH product.
- DIV: restoring division of magnitudes, one quotient bit per cycle.
- Final iteration edge writes HI/LO, applying sign fix-up in the same edge:
  - Product is negated if the operand signs differ; HI=upper WIDTH bits, LO=lower WIDTH bits.
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - MIN/−1 yields LO=MIN, HI=0 with no special case.
- `hi`/`lo` change only on that write or on reset.
- `stall` = `valid_i` & (MDU op | mfhi | mflo) & state ∈ {MUL, DIV}. A new op, or a HI/LO read, in DONE proceeds without stall and sees the new values.
- `flush` aborts iteration and leaves HI/LO unchanged. If `flush` and start coincide, `flush` wins.

## Timing
- Reset: state IDLE, counter 0, `hi`=`lo`=0, `busy`=`done`=0. `control_out`/`ex_illegal`/`stall` follow their inputs combinationally.
- Start accepted at edge k:
  - `busy`=1 for cycles k+1 … k+WIDTH.
  - HI/LO are written at edge k+WIDTH.
  - `done`=1 in cycle k+WIDTH+1 only.
- Divide-by-zero: `busy` never rises. HI/LO are written at edge k and `done` pulses in cycle k+1.
- Back-to-back: a start in the DONE cycle yields `done` exactly WIDTH+1 cycles later.
- Asynchronous reset mid-operation discards the op immediately; no `done` follows.

## Structure
- Shared package `mips_pkg` holds:
  - ALU code constants: AND=0, OR=1, ADD=2, NOP=3, DIV=4, MUL=5, SUB=6, SLT=7, SLL=8, SRL=9, XOR=10, NOR=11, SRA=12, MFHI=13, MFLO=14.
  - funct constants.
  - FSM state enum.
- One natural sub-module, `mdu_iter`: datapath registers and the iteration step. Decode and FSM stay in the top.

## Test plan
- Decode sweep: each listed funct with `ALUop`=10 gives the listed code. `funct`=3Fh → 3, `ex_illegal`=1. `ALUop`=01 → 6. `funct`=02h with `opcode`=1Ch → 5; with `opcode`=0 → 9.
- WIDTH=32 mul 7 × −3: `done` 33 cycles after start, HI=FFFFFFFFh, LO=FFFFFFEBh. `busy` high exactly 32 cycles.
- Div −7 / 2 gives LO=FFFFFFFDh, HI=FFFFFFFFh. Div 80000000h / FFFFFFFFh gives LO=80000000h, HI=0.
- Div 5 / 0: no busy; `done` next cycle; HI=5, LO=FFFFFFFFh.
- mflo presented 10 cycles into a mul: `stall`=1 until DONE, then 0 with the new LO visible.
- `flush` at cycle 5 of a div: returns to IDLE, no `done`, HI/LO hold prior values. `rst_n` low mid-mul: HI/LO=0, `busy`=0 immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions.
// Holds the 4-bit ALU operation codes, the R-type funct field values the
// ALU control decodes, and the state encoding of the multiply/divide FSM.
package mips_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_NOP  = 4'd3;
  localparam logic [3:0] ALU_DIV  = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_XOR  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_MFHI = 4'd13;
  localparam logic [3:0] ALU_MFLO = 4'd14;

  // R-type funct field values
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL_MUL = 6'h02;  // srl, or mul when opcode != 0
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath with the architectural HI/LO registers.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            capture operand magnitudes/signs and clear the counter
//   load_div0       divide by zero: write HI=a, LO=all-ones immediately
//   step_mul        perform one shift-add multiply iteration
//   step_div        perform one restoring-division iteration
//   a, b            signed operands (rs, rt)
//   last            the current iteration is the final one
//   hi, lo          architectural HI/LO
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             load_div0,
  input  logic             step_mul,
  input  logic             step_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, prod_fix;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    // MIN maps to itself, which is the correct unsigned magnitude.
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  assign last = (cnt_q == CNT_W'(WIDTH - 1));
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, mb_q};

    acc_step = acc_q;
    if (step_mul) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (step_div) begin
      // Negative trial difference: restore, quotient bit 0.
      acc_step = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // Sign fix-up is applied to the value produced by the final iteration.
    prod_fix = neg2_if(sa_q ^ sb_q, acc_step);
    quo_fix  = neg_if(sa_q ^ sb_q, acc_step[WIDTH-1:0]);
    rem_fix  = neg_if(sa_q, acc_step[2*WIDTH-1:WIDTH]);

    acc_d = acc_step;
    mb_d  = mb_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;

    if (load) begin
      acc_d = {{WIDTH{1'b0}}, mag(a)};
      mb_d  = mag(b);
      sa_d  = a[WIDTH-1];
      sb_d  = b[WIDTH-1];
      cnt_d = '0;
    end else if (step_mul || step_div) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load_div0) begin
      hi_d = a;
      lo_d = '1;
    end else if (step_mul && last) begin
      {hi_d, lo_d} = prod_fix;
    end else if (step_div && last) begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  // Operand/accumulator registers are only meaningful after a load.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    mb_q  <= mb_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// Execute-stage ALU control with an iterative multiply/divide unit.
// Decodes ALUop/funct/opcode into the 4-bit ALU operation code and sequences
// multi-cycle mul/div through mdu_iter, stalling EX while HI/LO are pending.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   valid_i, flush    instruction present in EX / squash EX and in-flight op
//   ALUop, funct, opcode  decode inputs
//   a, b              rs/rt operand values
//   control_out       ALU operation code
//   ex_illegal        unrecognised R-type funct
//   stall, busy, done pipeline hold / iterating / HI-LO just written
//   hi, lo            architectural HI/LO
module alu_ctrl_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             flush,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       funct,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       control_out,
  output logic             ex_illegal,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state_q, state_d;
  logic mdu_op, hilo_rd, start, run, b_zero, last, is_div;

  // ALUop=1x takes precedence over the x1 subtract case.
  always_comb begin
    control_out = ALU_ADD;
    ex_illegal  = 1'b0;
    if (ALUop[1]) begin
      unique case (funct)
        FN_ADD:     control_out = ALU_ADD;
        FN_SUB:     control_out = ALU_SUB;
        FN_AND:     control_out = ALU_AND;
        FN_OR:      control_out = ALU_OR;
        FN_SLT:     control_out = ALU_SLT;
        FN_SLL:     control_out = ALU_SLL;
        FN_SRA:     control_out = ALU_SRA;
        FN_XOR:     control_out = ALU_XOR;
        FN_NOR:     control_out = ALU_NOR;
        FN_DIV:     control_out = ALU_DIV;
        FN_MFHI:    control_out = ALU_MFHI;
        FN_MFLO:    control_out = ALU_MFLO;
        FN_SRL_MUL: control_out = (opcode != 6'd0) ? ALU_MUL : ALU_SRL;
        default: begin
          control_out = ALU_NOP;
          ex_illegal  = 1'b1;
        end
      endcase
    end else if (ALUop[0]) begin
      control_out = ALU_SUB;
    end
  end

  assign is_div  = (control_out == ALU_DIV);
  assign mdu_op  = is_div || (control_out == ALU_MUL);
  assign hilo_rd = (control_out == ALU_MFHI) || (control_out == ALU_MFLO);
  assign b_zero  = (b == '0);
  assign busy    = (state_q == MDU_MUL) || (state_q == MDU_DIV);
  assign done    = (state_q == MDU_DONE);
  assign start   = valid_i && mdu_op && !flush &&
                   ((state_q == MDU_IDLE) || (state_q == MDU_DONE));
  assign run     = busy && !flush;
  assign stall   = valid_i && (mdu_op || hilo_rd) && busy;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = MDU_IDLE;
    end else begin
      unique case (state_q)
        MDU_IDLE, MDU_DONE: begin
          if (start) begin
            if (!is_div)     state_d = MDU_MUL;
            else if (b_zero) state_d = MDU_DONE;
            else             state_d = MDU_DIV;
          end else begin
            state_d = MDU_IDLE;
          end
        end
        MDU_MUL, MDU_DIV: begin
          if (last) state_d = MDU_DONE;
        end
        default: state_d = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  mdu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mdu_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (start),
    .load_div0 (start && is_div && b_zero),
    .step_mul  (run && (state_q == MDU_MUL)),
    .step_div  (run && (state_q == MDU_DIV)),
    .a         (a),
    .b         (b),
    .last      (last),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   ALUop = 2'b00;
  logic [5:0]   funct = 6'h00;
  logic [5:0]   opcode = 6'h00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   control_out;
  logic         ex_illegal, stall, busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [5:0] fn_tbl   [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00,
                                6'h03, 6'h26, 6'h27, 6'h1A, 6'h10, 6'h12};
  logic [3:0] code_tbl [12] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd8,
                                4'd12, 4'd10, 4'd11, 4'd4, 4'd13, 4'd14};

  alu_ctrl_mdu #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .flush       (flush),
    .ALUop       (ALUop),
    .funct       (funct),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .control_out (control_out),
    .ex_illegal  (ex_illegal),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present an MDU op for exactly one edge (the start edge k).
  task automatic issue(input logic [5:0] fn, input logic [5:0] op,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk); #1;
    valid_i = 1'b1; ALUop = 2'b10; funct = fn; opcode = op; a = av; b = bv;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Cycle n = 1 is cycle k+1; done_at stays 0 if done never appears.
  task automatic wait_done(output int done_at, output int busy_cnt);
    done_at = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_at = n;
    end
  endtask

  initial begin
    int done_at, busy_cnt, stall_miss, seen;

    // Reset state
    #12;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Decode sweep
    ALUop = 2'b10; opcode = 6'h00;
    for (int i = 0; i < 12; i++) begin
      funct = fn_tbl[i];
      #1;
      check($sformatf("dec_fn%02h", fn_tbl[i]), 32'(control_out), 32'(code_tbl[i]));
    end
    funct = 6'h3F; #1;
    check("dec_illegal_code", 32'(control_out), 32'd3);
    check("dec_illegal_flag", 32'(ex_illegal), 32'd1);
    funct = 6'h02; opcode = 6'h1C; #1;
    check("dec_mul", 32'(control_out), 32'd5);
    opcode = 6'h00; #1;
    check("dec_srl", 32'(control_out), 32'd9);
    ALUop = 2'b01; funct = 6'h3F; #1;
    check("dec_aluop01", 32'(control_out), 32'd6);
    check("dec_aluop01_legal", 32'(ex_illegal), 32'd0);
    ALUop = 2'b00; #1;
    check("dec_aluop00", 32'(control_out), 32'd2);

    // Mul 7 x -3
    issue(6'h02, 6'h1C, 32'd7, 32'hFFFF_FFFD);
    wait_done(done_at, busy_cnt);
    check("mul_done_cycle", done_at, 33);
    check("mul_busy_cycles", busy_cnt, 32);
    check("mul_hi", hi, 32'hFFFF_FFFF);
    check("mul_lo", lo, 32'hFFFF_FFEB);

    // Div -7 / 2
    issue(6'h1A, 6'h00, 32'hFFFF_FFF9, 32'd2);
    wait_done(done_at, busy_cnt);
    check("div_done_cycle", done_at, 33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    // Div MIN / -1
    issue(6'h1A, 6'h00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(done_at, busy_cnt);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'h0);

    // Div 5 / 0
    issue(6'h1A, 6'h00, 32'd5, 32'd0);
    wait_done(done_at, busy_cnt);
    check("div0_busy", busy_cnt, 0);
    check("div0_done_cycle", done_at, 1);
    check("div0_hi", hi, 32'd5);
    check("div0_lo", lo, 32'hFFFF_FFFF);

    // mflo presented mid-mul (3 x 4)
    issue(6'h02, 6'h1C, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    valid_i = 1'b1; ALUop = 2'b10; funct = 6'h12; opcode = 6'h00;
    stall_miss = 0;
    seen = 0;
    for (int n = 0; n < 40 && seen == 0; n++) begin
      #1;
      if (done) seen = 1;
      else begin
        if (stall !== 1'b1) stall_miss++;
        @(negedge clk);
      end
    end
    check("mflo_stall_held", stall_miss, 0);
    check("mflo_done_seen", seen, 1);
    check("mflo_stall_released", 32'(stall), 32'd0);
    check("mflo_new_lo", lo, 32'd12);
    check("mflo_hi", hi, 32'd0);
    valid_i = 1'b0;

    // Flush during a divide
    issue(6'h1A, 6'h00, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    wait_done(done_at, busy_cnt);
    check("flush_no_done", done_at, 0);
    check("flush_hi", hi, 32'd0);
    check("flush_lo", lo, 32'd12);

    // Asynchronous reset mid-mul
    issue(6'h02, 6'h1C, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_done(done_at, busy_cnt);
    check("arst_no_done", done_at, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
